// File: rtl/id_ex_stage_if.sv
// Bus bundle between ID, the forwarding sources and the EX stage.
// The master drives the ID fields and forwarding inputs; the slave is the ID/EX stage.
interface id_ex_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
);
  logic              stall;
  logic              flush;
  logic              id_reg_write;
  logic              id_mem_to_reg;
  logic              id_mem_read;
  logic              id_mem_write;
  logic              id_alu_src;
  logic              id_reg_dst;
  logic [1:0]        id_alu_op;
  logic [5:0]        id_funct;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic [REG_W-1:0]  id_rs;
  logic [REG_W-1:0]  id_rt;
  logic [REG_W-1:0]  id_rd;
  logic              exmem_reg_write;
  logic [REG_W-1:0]  exmem_rd;
  logic [DATA_W-1:0] exmem_result;
  logic              memwb_reg_write;
  logic [REG_W-1:0]  memwb_rd;
  logic [DATA_W-1:0] memwb_result;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [3:0]        alu_control;
  logic [DATA_W-1:0] ex_store_data;
  logic [REG_W-1:0]  ex_dest;
  logic              ex_reg_write;
  logic              ex_mem_to_reg;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic [REG_W-1:0]  ex_rs;
  logic [REG_W-1:0]  ex_rt;
  logic              ex_valid;

  modport master (
    output stall, flush, id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write,
           id_alu_src, id_reg_dst, id_alu_op, id_funct, id_rs_data, id_rt_data, id_imm,
           id_rs, id_rt, id_rd, exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
    input  alu_a, alu_b, alu_control, ex_store_data, ex_dest, ex_reg_write, ex_mem_to_reg,
           ex_mem_read, ex_mem_write, ex_rs, ex_rt, ex_valid
  );

  modport slave (
    input  stall, flush, id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write,
           id_alu_src, id_reg_dst, id_alu_op, id_funct, id_rs_data, id_rt_data, id_imm,
           id_rs, id_rt, id_rd, exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
    output alu_a, alu_b, alu_control, ex_store_data, ex_dest, ex_reg_write, ex_mem_to_reg,
           ex_mem_read, ex_mem_write, ex_rs, ex_rt, ex_valid
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and ALU-control decode.
// All outputs derive from registered state plus the live EX/MEM and MEM/WB forwarding inputs.
module id_ex_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
) (
  input logic          clk,
  input logic          reset,
  id_ex_stage_if.slave bus
);
  logic              reg_write_q;
  logic              mem_to_reg_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic              alu_src_q;
  logic              reg_dst_q;
  logic [1:0]        alu_op_q;
  logic [5:0]        funct_q;
  logic [DATA_W-1:0] rs_data_q;
  logic [DATA_W-1:0] rt_data_q;
  logic [DATA_W-1:0] imm_q;
  logic [REG_W-1:0]  rs_q;
  logic [REG_W-1:0]  rt_q;
  logic [REG_W-1:0]  rd_q;
  logic              valid_q;

  // A bubble zeroes every field, so rs/rt = 0 can never match a forwarding source.
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      alu_src_q    <= 1'b0;
      reg_dst_q    <= 1'b0;
      alu_op_q     <= 2'b00;
      funct_q      <= 6'd0;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      valid_q      <= 1'b0;
    end else if (!bus.stall) begin
      reg_write_q  <= bus.id_reg_write;
      mem_to_reg_q <= bus.id_mem_to_reg;
      mem_read_q   <= bus.id_mem_read;
      mem_write_q  <= bus.id_mem_write;
      alu_src_q    <= bus.id_alu_src;
      reg_dst_q    <= bus.id_reg_dst;
      alu_op_q     <= bus.id_alu_op;
      funct_q      <= bus.id_funct;
      rs_data_q    <= bus.id_rs_data;
      rt_data_q    <= bus.id_rt_data;
      imm_q        <= bus.id_imm;
      rs_q         <= bus.id_rs;
      rt_q         <= bus.id_rt;
      rd_q         <= bus.id_rd;
      valid_q      <= 1'b1;
    end
  end

  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;

  // EX/MEM beats MEM/WB because it holds the younger result.
  always_comb begin
    fwd_rs = rs_data_q;
    if (bus.exmem_reg_write && (bus.exmem_rd != '0) && (bus.exmem_rd == rs_q)) begin
      fwd_rs = bus.exmem_result;
    end else if (bus.memwb_reg_write && (bus.memwb_rd != '0) && (bus.memwb_rd == rs_q)) begin
      fwd_rs = bus.memwb_result;
    end
  end

  always_comb begin
    fwd_rt = rt_data_q;
    if (bus.exmem_reg_write && (bus.exmem_rd != '0) && (bus.exmem_rd == rt_q)) begin
      fwd_rt = bus.exmem_result;
    end else if (bus.memwb_reg_write && (bus.memwb_rd != '0) && (bus.memwb_rd == rt_q)) begin
      fwd_rt = bus.memwb_result;
    end
  end

  logic [3:0] alu_ctl;

  // 4'b1111 is the ALU's pass-through of operand a, used for anything undecoded.
  always_comb begin
    alu_ctl = 4'b1111;
    unique case (alu_op_q)
      2'b00: alu_ctl = 4'b0010;
      2'b01: alu_ctl = 4'b0110;
      2'b10: begin
        case (funct_q)
          6'b100000: alu_ctl = 4'b0010;
          6'b100010: alu_ctl = 4'b0110;
          6'b100100: alu_ctl = 4'b0000;
          6'b100101: alu_ctl = 4'b0001;
          6'b101010: alu_ctl = 4'b0111;
          default:   alu_ctl = 4'b1111;
        endcase
      end
      default: alu_ctl = 4'b1111;
    endcase
  end

  assign bus.alu_a         = fwd_rs;
  assign bus.alu_b         = alu_src_q ? imm_q : fwd_rt;
  assign bus.alu_control   = alu_ctl;
  assign bus.ex_store_data = fwd_rt;
  assign bus.ex_dest       = reg_dst_q ? rd_q : rt_q;
  assign bus.ex_reg_write  = reg_write_q;
  assign bus.ex_mem_to_reg = mem_to_reg_q;
  assign bus.ex_mem_read   = mem_read_q;
  assign bus.ex_mem_write  = mem_write_q;
  assign bus.ex_rs         = rs_q;
  assign bus.ex_rt         = rt_q;
  assign bus.ex_valid      = valid_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table for single-cycle loads plus hand-written
// sequences for forwarding priority, stall, flush and reset.
module tb_id_ex_stage;
  logic clk;
  logic reset;

  id_ex_stage_if #(.DATA_W(32), .REG_W(5)) bus ();

  id_ex_stage #(.DATA_W(32), .REG_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fwd();
    bus.exmem_reg_write = 1'b0;
    bus.exmem_rd        = 5'd0;
    bus.exmem_result    = 32'd0;
    bus.memwb_reg_write = 1'b0;
    bus.memwb_rd        = 5'd0;
    bus.memwb_result    = 32'd0;
  endtask

  task automatic set_id(input logic [1:0] op, input logic [5:0] funct, input logic alu_src,
                        input logic reg_dst, input logic mem_write, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] rs_data,
                        input logic [31:0] rt_data, input logic [31:0] imm);
    bus.id_alu_op     = op;
    bus.id_funct      = funct;
    bus.id_alu_src    = alu_src;
    bus.id_reg_dst    = reg_dst;
    bus.id_mem_write  = mem_write;
    bus.id_reg_write  = !mem_write;
    bus.id_mem_read   = 1'b0;
    bus.id_mem_to_reg = 1'b0;
    bus.id_rs         = rs;
    bus.id_rt         = rt;
    bus.id_rd         = rd;
    bus.id_rs_data    = rs_data;
    bus.id_rt_data    = rt_data;
    bus.id_imm        = imm;
  endtask

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic        alu_src;
    logic        reg_dst;
    logic        mem_write;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic        ex_we;
    logic [4:0]  ex_rd;
    logic [31:0] ex_res;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_res;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [31:0] exp_st;
    logic [3:0]  exp_ctl;
    logic [4:0]  exp_dest;
  } vec_t;

  vec_t vecs[12];

  initial begin
    // name, op, funct, alu_src, reg_dst, mem_write, rs, rt, rd, rs_data, rt_data, imm,
    // ex_we, ex_rd, ex_res, wb_we, wb_rd, wb_res, exp_a, exp_b, exp_st, exp_ctl, exp_dest
    vecs[0]  = '{"add", 2'b10, 6'b100000, 1'b0, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7,
                 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd5, 32'd7, 32'd7, 4'b0010, 5'd3};
    vecs[1]  = '{"sw", 2'b00, 6'b000000, 1'b1, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3, 32'd10, 32'd7,
                 32'hFFFF_FFFC, 1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'hAB,
                 32'd10, 32'hFFFF_FFFC, 32'hAB, 4'b0010, 5'd2};
    vecs[2]  = '{"sub_op", 2'b01, 6'b000000, 1'b0, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3, 32'd9, 32'd3,
                 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd9, 32'd3, 32'd3, 4'b0110, 5'd3};
    vecs[3]  = '{"f_sub", 2'b10, 6'b100010, 1'b0, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7,
                 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd5, 32'd7, 32'd7, 4'b0110, 5'd3};
    vecs[4]  = '{"f_and", 2'b10, 6'b100100, 1'b0, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7,
                 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd5, 32'd7, 32'd7, 4'b0000, 5'd3};
    vecs[5]  = '{"f_or", 2'b10, 6'b100101, 1'b0, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7,
                 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd5, 32'd7, 32'd7, 4'b0001, 5'd3};
    vecs[6]  = '{"f_slt", 2'b10, 6'b101010, 1'b0, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7,
                 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd5, 32'd7, 32'd7, 4'b0111, 5'd3};
    vecs[7]  = '{"f_bad", 2'b10, 6'b000000, 1'b0, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7,
                 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd5, 32'd7, 32'd7, 4'b1111, 5'd3};
    vecs[8]  = '{"op_rsv", 2'b11, 6'b100000, 1'b0, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7,
                 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd5, 32'd7, 32'd7, 4'b1111, 5'd3};
    vecs[9]  = '{"rt_fwd_pri", 2'b10, 6'b100000, 1'b0, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3, 32'd5,
                 32'd7, 32'd0, 1'b1, 5'd2, 32'h55, 1'b1, 5'd2, 32'h66,
                 32'd5, 32'h55, 32'h55, 4'b0010, 5'd3};
    vecs[10] = '{"r0_nofwd", 2'b10, 6'b100000, 1'b0, 1'b1, 1'b0, 5'd0, 5'd2, 5'd3, 32'd5,
                 32'd7, 32'd0, 1'b1, 5'd0, 32'd99, 1'b1, 5'd0, 32'd88,
                 32'd5, 32'd7, 32'd7, 4'b0010, 5'd3};
    vecs[11] = '{"imm_rs_wb", 2'b00, 6'b000000, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd5,
                 32'd7, 32'h10, 1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 32'h77,
                 32'h77, 32'h10, 32'd7, 4'b0010, 5'd2};
  end

  initial begin
    reset     = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    clear_fwd();
    set_id(2'b10, 6'b100000, 1'b0, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0);
    tick();
    tick();
    check("rst_alu_control", 32'(bus.alu_control), 32'h2);
    check("rst_alu_a", bus.alu_a, 32'd0);
    check("rst_alu_b", bus.alu_b, 32'd0);
    check("rst_valid", 32'(bus.ex_valid), 32'd0);
    check("rst_ctrl", 32'({bus.ex_reg_write, bus.ex_mem_to_reg, bus.ex_mem_read,
                           bus.ex_mem_write}), 32'd0);
    check("rst_dest", 32'(bus.ex_dest), 32'd0);
    check("rst_store", bus.ex_store_data, 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      set_id(vecs[i].op, vecs[i].funct, vecs[i].alu_src, vecs[i].reg_dst, vecs[i].mem_write,
             vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].rs_data, vecs[i].rt_data, vecs[i].imm);
      bus.exmem_reg_write = vecs[i].ex_we;
      bus.exmem_rd        = vecs[i].ex_rd;
      bus.exmem_result    = vecs[i].ex_res;
      bus.memwb_reg_write = vecs[i].wb_we;
      bus.memwb_rd        = vecs[i].wb_rd;
      bus.memwb_result    = vecs[i].wb_res;
      tick();
      check({vecs[i].name, "_alu_a"}, bus.alu_a, vecs[i].exp_a);
      check({vecs[i].name, "_alu_b"}, bus.alu_b, vecs[i].exp_b);
      check({vecs[i].name, "_store"}, bus.ex_store_data, vecs[i].exp_st);
      check({vecs[i].name, "_ctl"}, 32'(bus.alu_control), 32'(vecs[i].exp_ctl));
      check({vecs[i].name, "_dest"}, 32'(bus.ex_dest), 32'(vecs[i].exp_dest));
      check({vecs[i].name, "_memw"}, 32'(bus.ex_mem_write), 32'(vecs[i].mem_write));
      check({vecs[i].name, "_regw"}, 32'(bus.ex_reg_write), 32'(!vecs[i].mem_write));
      check({vecs[i].name, "_valid"}, 32'(bus.ex_valid), 32'd1);
    end

    // Forwarding priority on rs, changed without a clock edge.
    clear_fwd();
    set_id(2'b10, 6'b100000, 1'b0, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0);
    tick();
    check("fw_none", bus.alu_a, 32'd5);
    bus.exmem_reg_write = 1'b1;
    bus.exmem_rd        = 5'd1;
    bus.exmem_result    = 32'd100;
    bus.memwb_reg_write = 1'b1;
    bus.memwb_rd        = 5'd1;
    bus.memwb_result    = 32'd200;
    #1;
    check("fw_exmem_wins", bus.alu_a, 32'd100);
    bus.exmem_reg_write = 1'b0;
    #1;
    check("fw_memwb", bus.alu_a, 32'd200);
    bus.exmem_rd = 5'd0;
    bus.memwb_rd = 5'd0;
    #1;
    check("fw_r0", bus.alu_a, 32'd5);
    clear_fwd();

    // Load then stall 3 cycles while ID churns.
    set_id(2'b00, 6'b000000, 1'b1, 1'b0, 1'b0, 5'd4, 5'd6, 5'd7, 32'h1000, 32'd3, 32'd8);
    bus.id_mem_read   = 1'b1;
    bus.id_mem_to_reg = 1'b1;
    tick();
    check("lw_alu_a", bus.alu_a, 32'h1000);
    check("lw_alu_b", bus.alu_b, 32'd8);
    check("lw_dest", 32'(bus.ex_dest), 32'd6);
    bus.stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      set_id(2'b10, 6'(c + 1), 1'b0, 1'b1, 1'b1, 5'(c + 9), 5'(c + 12), 5'(c + 20),
             32'(c + 300), 32'(c + 400), 32'(c + 500));
      tick();
      check("stall_alu_a", bus.alu_a, 32'h1000);
      check("stall_alu_b", bus.alu_b, 32'd8);
      check("stall_ctl", 32'(bus.alu_control), 32'h2);
      check("stall_ctrl", 32'({bus.ex_reg_write, bus.ex_mem_to_reg, bus.ex_mem_read,
                               bus.ex_mem_write}), 32'hE);
      check("stall_rs_rt", 32'({bus.ex_rs, bus.ex_rt}), 32'({5'd4, 5'd6}));
      check("stall_valid", 32'(bus.ex_valid), 32'd1);
    end

    bus.flush = 1'b1;
    tick();
    check("flush_valid", 32'(bus.ex_valid), 32'd0);
    check("flush_ctrl", 32'({bus.ex_reg_write, bus.ex_mem_to_reg, bus.ex_mem_read,
                             bus.ex_mem_write}), 32'd0);
    check("flush_alu_a", bus.alu_a, 32'd0);
    check("flush_rs_rt", 32'({bus.ex_rs, bus.ex_rt}), 32'd0);
    check("flush_ctl", 32'(bus.alu_control), 32'h2);
    bus.flush = 1'b0;
    bus.stall = 1'b0;

    // Reset arriving while stalled still clears.
    set_id(2'b10, 6'b100000, 1'b0, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0);
    tick();
    check("pre_rst_valid", 32'(bus.ex_valid), 32'd1);
    bus.stall = 1'b1;
    reset     = 1'b1;
    tick();
    check("rst_stall_valid", 32'(bus.ex_valid), 32'd0);
    check("rst_stall_alu_a", bus.alu_a, 32'd0);
    check("rst_stall_dest", 32'(bus.ex_dest), 32'd0);
    reset     = 1'b0;
    bus.stall = 1'b0;
    tick();
    check("post_rst_load", bus.alu_a, 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
